rifl_rx_commit_buf: RTL
=======================

Name: rifl_rx_commit_buf

Overview:
- Sits directly downstream of the RX CRC/frame-ID validator and the descrambler.
- Speculatively buffers each received frame beat-by-beat.
- Commits a frame to the output stream only when the validator's verdict on the frame's last beat is good and the frame is a data frame. Otherwise it rewinds and discards the frame.
- Presents committed frames on an AXI-Stream master interface with frame-granular tlast.

Parameters:
- FRAME_WIDTH, 256, frame size in bits; must be DWIDTH times a power of 2.
- DWIDTH, 64, beat width in bits.
- DEPTH_FRAMES, 4, buffer capacity in whole frames; power of 2, at least 2.
- STAT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; active-low, synchronous.
- rx_up  in  1  link up; low aborts any frame in progress.
- rx_valid  in  1  beat valid; beats within a frame are contiguous.
- rx_sof  in  1  first beat of a frame; qualified by rx_valid.
- rx_data  in  DWIDTH  descrambled beat; header is rx_data[DWIDTH-1-:2] on the sof beat.
- crc_good  in  1  validator verdict; sampled only on the last-beat cycle.
- m_axis_tdata  out  DWIDTH  committed beat.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tlast  out  1  last beat of a frame.
- m_axis_tready  in  1  downstream ready.
- overflow  out  1  one-cycle pulse: a frame was dropped because the buffer was full.
- frame_drop  out  1  one-cycle pulse: a data frame was dropped for a bad verdict or an abort.
- good_cnt  out  STAT_WIDTH  count of committed frames; saturating.
- drop_cnt  out  STAT_WIDTH  count of frame_drop plus overflow events; saturating.

Behaviour:
- Derived constants: BEATS = FRAME_WIDTH/DWIDTH. RAM holds DEPTH_FRAMES*BEATS entries.
- Pointers: spec_wptr and commit_wptr are beat-level. rptr is beat-level. frame_cnt tracks committed-but-unread frames.
- Reset: all outputs are 0, all pointers and counters are 0, and the write FSM is in IDLE.
- Write FSM has three states: IDLE, FILL, SKIP.
  - IDLE: on rx_valid & rx_sof & rx_up, beat index becomes 0.
    - If fewer than BEATS free entries remain (committed plus unread): go to SKIP and pulse overflow.
    - Else if the header is not 2'b01: go to SKIP silently; this is a control frame.
    - Else write the beat and go to FILL.
  - BEATS=1: the sof beat is also the last beat. Commit is evaluated in the same cycle and the FSM stays in IDLE.
  - FILL: each rx_valid beat is written at spec_wptr and spec_wptr increments. On beat index BEATS-1 (last beat):
    - If crc_good: commit_wptr <= spec_wptr+1, frame_cnt increments, good_cnt increments.
    - Else: spec_wptr <= commit_wptr, pulse frame_drop.
    - Return to IDLE.
  - Abort in FILL: rx_valid low, rx_up low, or a new rx_sof before the last beat.
    - Rewind spec_wptr to commit_wptr and pulse frame_drop.
    - A new sof in that same cycle is then handled as in IDLE, in the same cycle.
  - SKIP: consumes BEATS-1 further beats without writing, then returns to IDLE. An abort in SKIP returns to IDLE with no pulse.
- Read side is first-word-fall-through with a registered RAM read.
  - The first beat of a committed frame shows m_axis_tvalid exactly 2 cycles after the commit (last-beat) cycle, provided the output was empty.
  - Transfer on tvalid & tready; rptr increments on each transfer.
  - m_axis_tlast = 1 when rptr mod BEATS == BEATS-1. frame_cnt decrements on a tlast transfer.
  - Outputs hold stable while tvalid & ~tready.
  - Full throughput: one beat per cycle with tready held high.
- Simultaneous events:
  - A commit and a final-beat read in the same cycle leave frame_cnt unchanged.
  - Free-space check uses committed entries plus unread entries. Space freed by a same-cycle read is not counted.
- Pointer wrap: pointers are log2(DEPTH_FRAMES*BEATS)+1 bits, with the MSB used for full/empty disambiguation.
- Counters saturate at all-ones.
  - If overflow and frame_drop would both fire in one cycle, drop_cnt increments by 2.
- rst_n low mid-frame or mid-read: all state clears next edge. Any partially read frame is lost and m_axis_tvalid is 0 the next cycle.

Test Plan:
- Good frame: 4 beats 0x4000..01, ..02, ..03, ..04 (header 01), crc_good=1 on beat 4 -> 4 output beats in order starting 2 cycles later, tlast on beat 4, good_cnt=1.
- Bad verdict: same frame with crc_good=0 on beat 4 -> no output, frame_drop pulses 1 cycle, drop_cnt=1. A following good frame is output intact (rewind verified).
- Control frame: header 2'b10, crc_good=1 -> no output, no pulses, counters unchanged.
- Overflow: tready=0, send 5 good frames back-to-back -> frames 1-4 buffered, frame 5 raises overflow and drop_cnt=1. Releasing tready outputs exactly 16 beats, 4 tlasts.
- Abort: rx_up low after beat 2 of 4 -> frame_drop pulses, nothing output. The next frame is clean.
- Backpressure and wrap: tready toggling 1010 over 12 good frames -> all 48 beats in order with no duplicates, good_cnt=12, pointers wrap at least twice.

Source files
------------

// File: rtl/rifl_rx_commit_buf.sv
// Purpose : speculative RX frame buffer; commits a data frame only on a good
//           last-beat verdict, otherwise rewinds; drains over AXI-Stream.
// Latency : first beat of a committed frame is valid 2 cycles after its last
//           input beat.
// Backpr. : no input backpressure. A frame that cannot fit whole at sof is
//           skipped and flagged. The output holds while tvalid & ~tready.
// Ports   : clk/rst_n (sync, active-low); rx_* + crc_good from the validator;
//           m_axis_* master stream; overflow/frame_drop one-cycle pulses;
//           good_cnt/drop_cnt saturating stats.
module rifl_rx_commit_buf #(
  parameter int FRAME_WIDTH  = 256,
  parameter int DWIDTH       = 64,
  parameter int DEPTH_FRAMES = 4,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_up,
  input  logic                  rx_valid,
  input  logic                  rx_sof,
  input  logic [DWIDTH-1:0]     rx_data,
  input  logic                  crc_good,
  output logic [DWIDTH-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  overflow,
  output logic                  frame_drop,
  output logic [STAT_WIDTH-1:0] good_cnt,
  output logic [STAT_WIDTH-1:0] drop_cnt
);

  localparam int BEATS   = FRAME_WIDTH / DWIDTH;
  localparam int ENTRIES = DEPTH_FRAMES * BEATS;
  localparam int AW      = $clog2(ENTRIES);
  localparam int PW      = AW + 1;                 // extra MSB separates full from empty
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [PW-1:0] FREE_LIMIT = PW'(ENTRIES - BEATS);
  localparam logic [BW-1:0] LAST_IDX   = BW'(BEATS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_SKIP} state_t;

  state_t                r_state, w_state_nx;
  logic [BW-1:0]         r_bidx, w_bidx_nx;
  logic [PW-1:0]         r_spec_wptr, r_commit_wptr, r_rptr, r_fptr;
  logic [DWIDTH-1:0]     r_ram [ENTRIES];
  logic [DWIDTH-1:0]     r_out_dat;
  logic                  r_out_vld, r_out_last;
  logic                  r_ovf, r_drop;
  logic [STAT_WIDTH-1:0] r_good, r_dcnt;

  // write-side decode
  logic          w_sof, w_brk, w_free_ok, w_hdr_ok;
  logic          w_fill_abort, w_start_ovf, w_start_data, w_fill_beat;
  logic          w_last, w_commit, w_bad, w_drop, w_we;
  logic [PW-1:0] w_used, w_waddr, w_waddr_nx;
  // read side
  logic          w_avail, w_xfer, w_load, w_fetch_last;
  logic [STAT_WIDTH:0]   w_dsum;
  logic [STAT_WIDTH-1:0] w_dcnt_nx;

  // Occupancy is committed-but-unread beats; a read landing this same cycle
  // does not count as freed space.
  assign w_used    = r_commit_wptr - r_rptr;
  assign w_free_ok = (w_used <= FREE_LIMIT);
  assign w_hdr_ok  = (rx_data[DWIDTH-1 -: 2] == 2'b01);
  assign w_sof     = rx_valid & rx_sof & rx_up;
  // Anything that breaks a contiguous frame: gap, link down or a new sof.
  assign w_brk     = ~rx_valid | ~rx_up | rx_sof;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_bidx  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_bidx  <= w_bidx_nx;
    end
  end

  // Next-state logic. A sof restarts framing from any state, so an aborted
  // frame and the frame that aborted it are handled in the same cycle.
  always_comb begin
    w_state_nx = r_state;
    w_bidx_nx  = r_bidx;
    case (r_state)
      ST_FILL, ST_SKIP: begin
        if (w_brk || (r_bidx == LAST_IDX)) w_state_nx = ST_IDLE;
        else                               w_bidx_nx  = r_bidx + BW'(1);
      end
      default: ;
    endcase
    if (w_sof) begin
      w_bidx_nx = BW'(1);
      if (BEATS == 1)        w_state_nx = ST_IDLE;
      else if (w_start_data) w_state_nx = ST_FILL;
      else                   w_state_nx = ST_SKIP;
    end
  end

  // Output decode of the write FSM
  always_comb begin
    w_fill_abort = (r_state == ST_FILL) & w_brk;
    w_start_ovf  = w_sof & ~w_free_ok;
    w_start_data = w_sof & w_free_ok & w_hdr_ok;
    w_fill_beat  = (r_state == ST_FILL) & ~w_brk;
    w_last       = (w_fill_beat & (r_bidx == LAST_IDX)) | (w_start_data & (BEATS == 1));
    w_commit     = w_last & crc_good;
    w_bad        = w_last & ~crc_good;
    w_drop       = w_fill_abort | w_bad;
    w_we         = w_start_data | w_fill_beat;
    // A new frame always starts at the commit point, which also covers the
    // cycle where the previous speculative frame is being rewound.
    w_waddr      = w_start_data ? r_commit_wptr : r_spec_wptr;
    w_waddr_nx   = w_waddr + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_we) r_ram[w_waddr[AW-1:0]] <= rx_data;
  end

  assign w_avail      = (r_fptr != r_commit_wptr);
  assign w_xfer       = r_out_vld & m_axis_tready;
  assign w_load       = w_avail & (~r_out_vld | m_axis_tready);
  assign w_fetch_last = (BEATS == 1) ? 1'b1 : (r_fptr[BW-1:0] == LAST_IDX);

  // Overflow and drop can coincide (abort + full at the same sof): add both.
  assign w_dsum    = {1'b0, r_dcnt} + {{STAT_WIDTH{1'b0}}, w_start_ovf}
                                    + {{STAT_WIDTH{1'b0}}, w_drop};
  assign w_dcnt_nx = w_dsum[STAT_WIDTH] ? '1 : w_dsum[STAT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_spec_wptr   <= '0;
      r_commit_wptr <= '0;
      r_rptr        <= '0;
      r_fptr        <= '0;
      r_out_dat     <= '0;
      r_out_vld     <= 1'b0;
      r_out_last    <= 1'b0;
      r_ovf         <= 1'b0;
      r_drop        <= 1'b0;
      r_good        <= '0;
      r_dcnt        <= '0;
    end else begin
      if (w_bad || (w_fill_abort && !w_start_data)) r_spec_wptr <= r_commit_wptr;
      else if (w_we)                                r_spec_wptr <= w_waddr_nx;
      if (w_commit) r_commit_wptr <= w_waddr_nx;

      // Single output register doubles as the RAM read register (FWFT).
      if (w_load) begin
        r_out_dat  <= r_ram[r_fptr[AW-1:0]];
        r_out_last <= w_fetch_last;
        r_out_vld  <= 1'b1;
        r_fptr     <= r_fptr + PW'(1);
      end else if (w_xfer) begin
        r_out_vld  <= 1'b0;
      end
      if (w_xfer) r_rptr <= r_rptr + PW'(1);

      r_ovf  <= w_start_ovf;
      r_drop <= w_drop;
      if (w_commit && (r_good != '1)) r_good <= r_good + STAT_WIDTH'(1);
      r_dcnt <= w_dcnt_nx;
    end
  end

  assign m_axis_tdata  = r_out_dat;
  assign m_axis_tvalid = r_out_vld;
  assign m_axis_tlast  = r_out_last;
  assign overflow      = r_ovf;
  assign frame_drop    = r_drop;
  assign good_cnt      = r_good;
  assign drop_cnt      = r_dcnt;

endmodule
